// File: rtl/t08_pkg.sv
// Shared definitions for the t08 datapath: ALU opcode encoding, load/store FSM states
// and helpers that classify memory operations.
package t08_pkg;

    typedef enum logic [5:0] {
        ADD  = 6'd0,
        SUB  = 6'd1,
        SLL  = 6'd2,
        SLT  = 6'd3,
        SLTU = 6'd4,
        XOR  = 6'd5,
        SRL  = 6'd6,
        SRA  = 6'd7,
        OR   = 6'd8,
        AND  = 6'd9,
        LB   = 6'd20,
        LH   = 6'd21,
        LW   = 6'd22,
        LBU  = 6'd23,
        LHU  = 6'd24,
        SB   = 6'd25,
        SH   = 6'd26,
        SW   = 6'd27
    } alu_operations;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        REQ   = 3'd1,
        WAIT  = 3'd2,
        DONE  = 3'd3,
        FAULT = 3'd4
    } mem_state_t;

    localparam logic [5:0] OP_MEM_FIRST = 6'd20;
    localparam logic [5:0] OP_MEM_LAST  = 6'd27;

    function automatic logic is_mem_op(input logic [5:0] op);
        return (op >= OP_MEM_FIRST) && (op <= OP_MEM_LAST);
    endfunction

    function automatic logic is_store_op(input alu_operations op);
        return (op == SB) || (op == SH) || (op == SW);
    endfunction

    // Halves need an even address, words need a 4-byte aligned one.
    function automatic logic is_misaligned(input alu_operations op, input logic [1:0] a);
        logic mis;
        mis = 1'b0;
        case (op)
            LH, LHU, SH: mis = a[0];
            LW, SW:      mis = (a != 2'b00);
            default:     mis = 1'b0;
        endcase
        return mis;
    endfunction

endpackage

// File: rtl/t08_lane_align.sv
// Byte-lane steering for the load/store unit: store replication/strobes and load
// extraction/extension. Low address bits that a given size ignores are forced to alignment.
module t08_lane_align
    import t08_pkg::*;
(
    input  alu_operations op,
    input  logic [1:0]    a,
    input  logic [31:0]   store_data,
    input  logic [31:0]   rdata,
    output logic [31:0]   wdata,
    output logic [3:0]    wstrb,
    output logic [31:0]   load_data
);

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    always_comb begin
        sel_byte  = 8'(rdata >> {a, 3'b000});
        sel_half  = 16'(rdata >> {a[1], 4'b0000});
        wdata     = 32'd0;
        wstrb     = 4'b0000;
        load_data = 32'd0;
        case (op)
            LB:  load_data = {{24{sel_byte[7]}}, sel_byte};
            LBU: load_data = {24'd0, sel_byte};
            LH:  load_data = {{16{sel_half[15]}}, sel_half};
            LHU: load_data = {16'd0, sel_half};
            LW:  load_data = rdata;
            SB: begin
                wdata = {4{store_data[7:0]}};
                wstrb = 4'b0001 << a;
            end
            SH: begin
                wdata = {2{store_data[15:0]}};
                wstrb = 4'b0011 << {a[1], 1'b0};
            end
            SW: begin
                wdata = store_data;
                wstrb = 4'b1111;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/t08_mem_access.sv
// Load/store unit: one word-aligned data-memory access per memory instruction.
// Optional misaligned-access trap compiled in with T08_MISALIGN_TRAP_EN.
module t08_mem_access
    import t08_pkg::*;
(
    input  logic        clk,
    input  logic        nRst,
    input  logic [5:0]  alu_control,
    input  logic        mem_valid,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    input  logic [31:0] bus_rdata,
    input  logic        bus_busy,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_wstrb,
    output logic        bus_read,
    output logic        bus_write,
    output logic [31:0] load_data,
    output logic        stall,
    output logic        done,
    output logic        fault,
    output mem_state_t  state_dbg
);

    // Handshake: start is sampled when mem_valid=1 with a memory op in IDLE; upstream
    // holds its inputs while stall=1, and done pulses for one cycle on completion.
    mem_state_t    state_q, state_d;
    alu_operations op_q;
    logic [31:0]   addr_q, data_q, load_q;
    logic [31:0]   lane_wdata, lane_load;
    logic [3:0]    lane_wstrb;
    logic          mem_op, start, in_req;

    assign mem_op = is_mem_op(alu_control);
    assign start  = mem_valid && mem_op && (state_q == IDLE);

    t08_lane_align u_lane (
        .op         (op_q),
        .a          (addr_q[1:0]),
        .store_data (data_q),
        .rdata      (bus_rdata),
        .wdata      (lane_wdata),
        .wstrb      (lane_wstrb),
        .load_data  (lane_load)
    );

    always_ff @(posedge clk or posedge nRst) begin
        if (nRst) begin
            state_q <= IDLE;
            op_q    <= ADD;
            addr_q  <= 32'd0;
            data_q  <= 32'd0;
            load_q  <= 32'd0;
        end else begin
            state_q <= state_d;
            if (start) begin
                op_q   <= alu_operations'(alu_control);
                addr_q <= addr;
                data_q <= store_data;
            end
            if (state_q == WAIT && !bus_busy) begin
                load_q <= lane_load;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = REQ;
`ifdef T08_MISALIGN_TRAP_EN
                    if (is_misaligned(alu_operations'(alu_control), addr[1:0])) begin
                        state_d = FAULT;
                    end
`endif
                end
            end
            REQ:     state_d = WAIT;
            WAIT:    if (!bus_busy) state_d = DONE;
            DONE:    state_d = IDLE;
            FAULT:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Bus request fields are only live for the single REQ cycle.
    assign in_req    = (state_q == REQ);
    assign bus_read  = in_req && !is_store_op(op_q);
    assign bus_write = in_req && is_store_op(op_q);
    assign bus_addr  = {addr_q[31:2], 2'b00};
    assign bus_wdata = in_req ? lane_wdata : 32'd0;
    assign bus_wstrb = in_req ? lane_wstrb : 4'b0000;
    assign load_data = load_q;
    assign done      = (state_q == DONE) || (state_q == FAULT);
    assign stall     = mem_valid && mem_op && (state_q != DONE) && (state_q != FAULT);
    assign state_dbg = state_q;

`ifdef T08_MISALIGN_TRAP_EN
    assign fault = (state_q == FAULT);
`else
    assign fault = 1'b0;
`endif

endmodule

// File: doc/t08_mem_access.md
# t08_mem_access

Load/store unit that sits directly downstream of `t08_alu`. It takes the effective address the ALU computes for LB/LH/LW/LBU/LHU/SB/SH/SW (`reg1 + immediate`) and runs one word-aligned access on the data-memory bus. It generates byte strobes and lane-replicated store data, and returns sign- or zero-extended load data. The pipeline is stalled until the access completes.

## Interface
Parameters:
- none. Widths are fixed at 32-bit data and 6-bit `alu_control`.

Ports:
- `clk`  in  1  system clock; all state updates on the rising edge.
- `nRst`  in  1  reset, **asynchronous, active-high** (asserted = 1).
- `alu_control`  in  6  operation code, same encoding as the ALU (`LB`=20 … `SW`=27).
- `mem_valid`  in  1  instruction in the memory stage requests an access.
- `addr`  in  32  effective address, taken from ALU `data_out`.
- `store_data`  in  32  `reg2` value for stores.
- `bus_rdata`  in  32  word returned by memory.
- `bus_busy`  in  1  memory is working; data is valid when low in WAIT.
- `bus_addr`  out  32  word-aligned address, `{addr[31:2],2'b00}`.
- `bus_wdata`  out  32  lane-replicated store data.
- `bus_wstrb`  out  4  byte enables.
- `bus_read`, `bus_write`  out  1  one-cycle request strobes.
- `load_data`  out  32  extended load result.
- `stall`  out  1  hold the upstream pipeline.
- `done`  out  1  one-cycle completion pulse.
- `fault`  out  1  misaligned-access pulse (only when the trap feature is compiled in).

## Operation
- A **start** occurs when `mem_valid` is 1, `alu_control` is in 20..27, and the state is IDLE.
  - On start, `addr`, `store_data` and the op are captured into internal registers.
- **States:**
  - IDLE → REQ on start. Under the trap feature, a misaligned start goes to FAULT instead.
  - REQ: exactly one of `bus_read`/`bus_write` is 1, with `bus_addr`, `bus_wstrb` and `bus_wdata` driven. Next state is WAIT.
  - WAIT: strobes are 0. The FSM stays in WAIT while `bus_busy`=1. When `bus_busy`=0, `bus_rdata` is captured and the FSM goes to DONE.
  - DONE: `done`=1, then IDLE.
  - FAULT: `fault`=1 and `done`=1, with no bus access, then IDLE.
- **Store lanes** (`a` = `addr[1:0]`):
  - SB: `wdata`={4{d[7:0]}}, `wstrb`=`4'b0001<<a`.
  - SH: `wdata`={2{d[15:0]}}, `wstrb`=`4'b0011<<{a[1],1'b0}`.
  - SW: `wdata`=d, `wstrb`=1111.
  - Loads drive `wstrb`=0000.
- **Load extraction:**
  - LB/LBU take byte `rdata[8a+:8]`. LH/LHU take half `rdata[16a[1]+:16]`. LW takes the whole word.
  - LB/LH sign-extend from the top bit; LBU/LHU zero-extend.
  - For stores, `load_data` is 0.
- `load_data` is registered. It is valid from DONE and held until the next completion.
- **Misaligned:** LH/LHU/SH with `a[0]`=1, or LW/SW with `a`≠0.
- `stall` = `mem_valid` & op in 20..27 & state≠DONE & state≠FAULT (combinational).
  - Upstream holds `alu_control`/`addr`/`store_data` stable while `stall`=1.
  - For non-memory ops, `stall`=0 and the FSM stays idle.
- **Reset:** async assert forces IDLE and clears the captured registers, `load_data`, and all bus outputs.
  - Strobes drop in the same cycle, even mid-access; the access is abandoned.

## Timing
- Zero-wait access: start in cycle 0 → REQ in cycle 1 → WAIT in cycle 2 (busy=0) → DONE in cycle 3.
  - `stall` is 1 in cycles 0–2 and 0 in cycle 3.
- Each busy cycle in WAIT adds one cycle of latency.
- Back-to-back accesses: the cycle after DONE is IDLE and may start again, so the minimum issue interval is 4 cycles.
- Misaligned access with the trap feature: start in cycle 0 → FAULT in cycle 1 (`fault`=`done`=1, `stall`=0).
- `mem_valid` falling mid-access does not abort the access; `stall` simply deasserts.

## Configuration
- `T08_MISALIGN_TRAP_EN` defined:
  - Misaligned accesses go to FAULT, with no bus strobe and `load_data` unchanged.
- `T08_MISALIGN_TRAP_EN` undefined:
  - No FAULT state; `fault` is tied to 0.
  - Misaligned accesses proceed with the low address bits forced to alignment (`a[0]`=0 for halves, `a`=00 for words) for both strobes and extraction.

## Structure
- Shared package `t08_pkg` holds:
  - the `alu_operations` enum, which the ALU and its bench also import;
  - the `mem_state_t` enum (IDLE, REQ, WAIT, DONE, FAULT);
  - constants `OP_MEM_FIRST`=20 and `OP_MEM_LAST`=27.
- Sub-module `t08_lane_align` (combinational) contains the store lane replication/strobe logic and the load extraction/extension logic. It is reused by the bench as a model.

## Test plan
- SW, `addr`=0x100, `store_data`=0xDEADBEEF, busy=0 → cycle 1: `bus_write`=1, `bus_addr`=0x100, `wstrb`=1111, `wdata`=0xDEADBEEF; `done` in cycle 3; `stall` high for 3 cycles.
- SB, `addr`=0x103, data=0x000000A5 → `wstrb`=1000, `wdata`=0xA5A5A5A5.
- LB, `addr`=0x102, `rdata`=0x12F03456 → `load_data`=0xFFFFFFF0. LBU, same inputs → 0x000000F0. LH, `addr`=0x102 → 0x000012F0.
- LW with `bus_busy` held 3 cycles in WAIT → `done` in cycle 6, `load_data`=`rdata`, exactly one `bus_read` pulse.
- LW, `addr`=0x101, with the trap feature → `fault`=`done`=1 in cycle 1, no `bus_read`. Without the feature → `bus_addr`=0x100 and the full word is loaded.
- Reset asserted in WAIT → `bus_*`, `done`, `stall`-related state and `load_data` go to 0 immediately; the next SW starts cleanly from IDLE.
